// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Loadable up/down modulo counter with wrap-or-saturate ends.
// Revision : 1.0
// ============================================================================
module mod_updown_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULO   = 256,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH:0]   C_MOD = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULO - 64'd1);
  localparam logic             C_SAT = (SATURATE != 0);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH out of range 2..32");
    end
    if (MODULO < 64'd2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
      $error("mod_updown_counter: MODULO out of range 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_load;

  // One extra bit: the increment hits MODULO exactly at the top end and the
  // decrement borrows into the MSB at zero, so full-range moduli never alias.
  assign w_inc  = {1'b0, count_q} + (WIDTH+1)'(1);
  assign w_dec  = {1'b0, count_q} - (WIDTH+1)'(1);
  assign w_load = (data_in > C_MAX) ? C_MAX : data_in;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (load_en) begin
      count_d = w_load;
    end else if (en) begin
      if (up_dn) begin
        if (w_inc == C_MOD) begin
          if (C_SAT) begin
            sat_d = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = w_inc[WIDTH-1:0];
        end
      end else begin
        if (w_dec[WIDTH]) begin
          if (C_SAT) begin
            sat_d = 1'b1;
          end else begin
            count_d = C_MAX;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = w_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count_out = count_q;
  assign wrap      = wrap_q;
  assign sat       = sat_q;
  assign tc        = up_dn ? (count_q == C_MAX) : (count_q == '0);

endmodule
`default_nettype wire
